// File: rtl/pim_pkg.sv
// Shared PIM definitions: operating modes, output-sequencer states and encoder lane geometry.
// Pure declarations; no latency or backpressure of its own.
package pim_pkg;

    localparam int NUM_LANES = 4;
    localparam int ENC_W     = 4;
    localparam int HALF_W    = NUM_LANES * ENC_W;

    typedef enum logic [2:0] {
        PIM_OFF      = 3'b000,
        PIM_PARALLEL = 3'b101,
        PIM_RBR      = 3'b110
    } pim_mode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT_ENC,
        ST_OUT,
        ST_DONE
    } enc_seq_state_e;

    function automatic logic mode_legal(input logic [2:0] m);
        return (m == PIM_PARALLEL) || (m == PIM_RBR);
    endfunction

endpackage

// File: rtl/enc_word_packer.sv
// Packs two 16-bit encoder half-words into one 32-bit word; clear wins over capture.
// Registered, one cycle from capture to word_o; no backpressure (caller sequences it).
module enc_word_packer
    import pim_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  cap_i,
    input  logic                  clr_i,
    input  logic                  hi_i,
    input  logic [HALF_W-1:0]     half_i,
    output logic [2*HALF_W-1:0]   word_o
);

    logic [2*HALF_W-1:0] word_q, word_d;

    always_comb begin
        word_d = word_q;
        if (clr_i) begin
            word_d = '0;
        end else if (cap_i) begin
            if (hi_i) begin
                word_d[2*HALF_W-1:HALF_W] = half_i;
            end else begin
                word_d[HALF_W-1:0] = half_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            word_q <= '0;
        end else begin
            word_q <= word_d;
        end
    end

    assign word_o = word_q;

endmodule

// File: rtl/enc_out_seq.sv
// Sequences eFlash reads through the output encoder and streams two reads per 32-bit word.
// Capture ENC_LAT cycles after each ack; word held on valid_o until ready_i, abort wins over all.
module enc_out_seq
    import pim_pkg::*;
#(
    parameter int ENC_LAT  = 1,
    parameter int RD_CNT_W = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    input  logic [2:0]          pim_mode_i,
    input  logic [RD_CNT_W-1:0] num_reads_i,
    input  logic                abort_i,
    output logic                eflash_req_o,
    input  logic                eflash_ack_i,
    output logic [2:0]          enc_mode_o,
    input  logic [15:0]         enc_out_i,
    output logic [31:0]         data_o,
    output logic                valid_o,
    input  logic                ready_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o
);

    localparam logic [1:0] LAT_INIT = 2'(ENC_LAT - 1);

    enc_seq_state_e      state_q, state_d;
    logic [2:0]          mode_q, mode_d;
    logic [RD_CNT_W-1:0] cnt_q, cnt_d;
    logic [RD_CNT_W-1:0] idx_q, idx_d, idx_inc;
    logic [1:0]          lat_q, lat_d;
    logic                err_q, err_d;
    logic                cap, clr;
    logic [31:0]         word;

    assign idx_inc = idx_q + RD_CNT_W'(1);

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        lat_d   = lat_q;
        err_d   = 1'b0;
        cap     = 1'b0;
        clr     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if (mode_legal(pim_mode_i) && (num_reads_i != '0)) begin
                        mode_d  = pim_mode_i;
                        cnt_d   = num_reads_i;
                        idx_d   = '0;
                        clr     = 1'b1;
                        state_d = ST_REQ;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                if (eflash_ack_i) begin
                    lat_d   = LAT_INIT;
                    state_d = ST_WAIT_ENC;
                end
            end
            ST_WAIT_ENC: begin
                if (lat_q == '0) begin
                    cap     = 1'b1;
                    idx_d   = idx_inc;
                    // A full word (even index) or the last read flushes to the host.
                    state_d = (!idx_inc[0] || (idx_inc == cnt_q)) ? ST_OUT : ST_REQ;
                end else begin
                    lat_d = lat_q - 2'd1;
                end
            end
            ST_OUT: begin
                if (ready_i) begin
                    clr     = 1'b1;
                    state_d = (idx_q == cnt_q) ? ST_DONE : ST_REQ;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (abort_i) begin
            state_d = ST_IDLE;
            mode_d  = '0;
            cnt_d   = '0;
            idx_d   = '0;
            lat_d   = '0;
            err_d   = 1'b0;
            cap     = 1'b0;
            clr     = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            mode_q  <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            lat_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            lat_q   <= lat_d;
            err_q   <= err_d;
        end
    end

    enc_word_packer u_packer (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .cap_i  (cap),
        .clr_i  (clr),
        .hi_i   (idx_q[0]),
        .half_i (enc_out_i),
        .word_o (word)
    );

    assign eflash_req_o = (state_q == ST_REQ);
    assign valid_o      = (state_q == ST_OUT);
    assign data_o       = valid_o ? word : '0;
    assign busy_o       = (state_q != ST_IDLE);
    assign done_o       = (state_q == ST_DONE);
    assign err_o        = err_q;
    assign enc_mode_o   = busy_o ? mode_q : 3'b000;

endmodule

// File: doc/enc_out_seq.md
Name: enc_out_seq

Overview:
- Sequences a multi-read PIM output transfer through the 4-lane output-buffer encoder.
- For each read: requests an eFlash read, drives the encoder mode, and waits out the encoder register latency. It then captures the four 4-bit lane codes.
- Packs two reads per 32-bit word and streams words to the host side over a valid/ready handshake.
- Sits between the PIM control FSM / eFlash read port and the output-buffer FIFO.

Parameters:
- ENC_LAT, 1: cycles from eflash_ack_i to valid encoder output on enc_out_i (range 1..3).
- RD_CNT_W, 4: width of the per-operation read-count field.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous and active-low.
- start_i  in  1  one-cycle pulse that starts an operation; sampled only in IDLE.
- pim_mode_i  in  3  requested mode; PARALLEL=3'b101, RBR=3'b110; others are illegal.
- num_reads_i  in  RD_CNT_W  reads per operation, 1..15; 0 is illegal.
- abort_i  in  1  forces a return to IDLE.
- eflash_req_o  out  1  read request level.
- eflash_ack_i  in  1  one-cycle pulse; eFlash data is at the encoder inputs this cycle.
- enc_mode_o  out  3  mode driven to the encoder's pim_mode_i.
- enc_out_i  in  16  packed encoder lanes; lane i at [4i+3:4i].
- data_o  out  32  packed word.
- valid_o  out  1  data_o is valid.
- ready_i  in  1  consumer accepts the word.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle pulse when the operation completes.
- err_o  out  1  one-cycle pulse when a start is rejected.

Behaviour:
Reset values:
- All outputs are 0. The FSM is in IDLE. Counters and registers are 0.

FSM states: IDLE, REQ, WAIT_ENC, OUT, DONE.

IDLE:
- enc_mode_o=3'b000, so the encoder outputs zeros.
- On start_i with a legal mode and num_reads_i!=0:
  - latch mode and read count;
  - clear the read index and the word register;
  - go to REQ next cycle.
- On start_i with an illegal mode or num_reads_i==0: err_o pulses the next cycle and the FSM stays in IDLE.

REQ:
- eflash_req_o=1 and is held until eflash_ack_i.
- On the ack cycle, go to WAIT_ENC with the latency counter=ENC_LAT-1.
- eflash_req_o deasserts the cycle after the ack.
- Any ack outside REQ is ignored.

WAIT_ENC:
- Decrement the counter. When it reaches 0, capture enc_out_i on that edge. The capture cycle is exactly ENC_LAT cycles after the ack cycle.
- Placement:
  - even read index → word[15:0];
  - odd read index → word[31:16].
- Then increment the read index.
- If the index is now even, or it equals the latched count, go to OUT. Otherwise go to REQ.

OUT:
- valid_o=1 and data_o=word. Both are held stable until ready_i.
- On valid_o&&ready_i, clear the word register (an odd final count leaves [31:16]=0).
- Next state: DONE if all reads are done, else REQ.
- ready_i has no effect when valid_o=0.

DONE:
- done_o=1 for one cycle, then IDLE.

While busy:
- enc_mode_o equals the latched mode from the cycle after start acceptance until DONE inclusive.
- start_i is ignored; no err_o is raised.

abort_i:
- Has priority over every transition in any state.
- Next cycle: IDLE with outputs at reset values; no done_o.
- A word pending in OUT is dropped.
- Simultaneous abort_i and valid&&ready: the transfer counts as accepted, then the FSM goes to IDLE.

Reset mid-operation: immediate return to IDLE and reset values; no done_o.

Word count per operation: ceil(num_reads/2).

Decomposition:
- Shared package pim_pkg holds:
  - the pim_mode_e enum (PIM_PARALLEL=3'b101, PIM_RBR=3'b110, plus existing modes);
  - the enc_seq_state_e enum;
  - the NUM_LANES=4 and ENC_W=4 constants.
- One natural sub-module, enc_word_packer: a 16-to-32 half-word packer with capture, clear, and a half-select input.
- The FSM and counters stay in the top level.

Test Plan:
1. PARALLEL, num_reads=2, ENC_LAT=1:
   - acks at cycles 3 and 8; enc_out_i=16'hA5C3 then 16'h1234;
   - expect one word data_o=32'h1234A5C3;
   - then done_o one cycle after the handshake;
   - enc_mode_o=3'b101 throughout.
2. RBR, num_reads=3, ready_i held low for 5 cycles on word 0:
   - expect data_o and valid_o stable throughout the stall;
   - second word = {16'h0000, read2};
   - exactly two words total.
3. start_i with pim_mode_i=3'b010 or num_reads_i=0:
   - expect err_o one pulse, busy_o=0, eflash_req_o=0.
4. ENC_LAT=3:
   - expect capture exactly 3 cycles after ack;
   - enc_out_i changed 1 cycle earlier must not be captured.
5. abort_i asserted in WAIT_ENC, and again in OUT with ready_i=0:
   - expect IDLE next cycle, valid_o=0, no done_o;
   - a new start then runs normally.
6. rst_ni asserted during REQ:
   - expect eflash_req_o=0 asynchronously and all outputs 0;
   - an ack arriving after reset is ignored.
